// File: rtl/dmem_responder.sv
// dmem_responder
//
// Data-side memory responder for the pipelined MIPS core. It decodes the
// memory-stage address into a word-addressed data RAM or a small MMIO
// window. The window holds a debug TX FIFO, a cycle counter and a status
// register. The FIFO is drained through a valid/ready stream.
//
// Optional feature macro: DMEM_CYCLE_COUNTER_EN.
//   Defined:   the 32-bit cycle counter is built, and CYCLES loads return it.
//   Undefined: no counter is built, and CYCLES loads return 0.
//
// Ports:
//   clk        in   system clock; all state updates on the rising edge
//   reset      in   synchronous, active-high reset
//   MemWriteM  in   store strobe for the current cycle
//   ALUOutM    in   byte address (bits [1:0] ignored)
//   WriteDataM in   store data
//   ReadDataM  out  load data, combinational from the current address
//   dbg_valid  out  TX FIFO head is valid
//   dbg_data   out  TX FIFO head word
//   dbg_ready  in   consumer accepts the head this cycle

module dmem_responder #(
    parameter int ADDR_W  = 6,
    parameter int FIFO_AW = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        dbg_valid,
    output logic [31:0] dbg_data,
    input  logic        dbg_ready
);

    localparam int RAM_WORDS  = 1 << ADDR_W;
    localparam int FIFO_DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_C = {1'b1, {FIFO_AW{1'b0}}};

    // MMIO word offsets within the top 256-byte page (address bits [7:2])
    localparam logic [5:0] OFF_TXDATA = 6'h3C;
    localparam logic [5:0] OFF_CYCLES = 6'h3D;
    localparam logic [5:0] OFF_STATUS = 6'h3E;

    logic [31:0] ram_mem  [0:RAM_WORDS-1];
    logic [31:0] fifo_mem [0:FIFO_DEPTH-1];

    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW:0]   count_q,  count_d;
    logic               overflow_q, overflow_d;

    logic              is_mmio;
    logic [5:0]        mmio_off;
    logic [ADDR_W-1:0] ram_idx;
    logic              push_try;
    logic              push_ok;
    logic              pop;
    logic              status_wr;
    logic              fifo_full;
    logic              fifo_empty;
    logic [7:0]        count_byte;
    logic [31:0]       cycles_val;
    logic              unused_addr_lsbs;

    assign unused_addr_lsbs = ^ALUOutM[1:0];

    assign is_mmio    = (ALUOutM[31:8] == 24'hFFFFFF);
    assign mmio_off   = ALUOutM[7:2];
    // Upper address bits are deliberately not checked: the RAM aliases.
    assign ram_idx    = ALUOutM[ADDR_W+1:2];

    assign fifo_full  = (count_q == DEPTH_C);
    assign fifo_empty = (count_q == '0);
    assign count_byte = 8'(count_q);

    // Head is derived purely from registered state, so it never depends
    // combinationally on dbg_ready.
    assign dbg_valid  = !fifo_empty;
    assign dbg_data   = fifo_mem[rd_ptr_q];

    assign pop        = dbg_valid && dbg_ready;
    assign push_try   = MemWriteM && is_mmio && (mmio_off == OFF_TXDATA);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok    = push_try && (!fifo_full || pop);
    assign status_wr  = MemWriteM && is_mmio && (mmio_off == OFF_STATUS);

`ifdef DMEM_CYCLE_COUNTER_EN
    logic [31:0] cycles_q, cycles_d;

    assign cycles_d   = cycles_q + 32'd1;
    assign cycles_val = cycles_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cycles_q <= '0;
        end else begin
            cycles_q <= cycles_d;
        end
    end
`else
    assign cycles_val = 32'h0;
`endif

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (push_ok && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push_ok) begin
            count_d = count_q - 1'b1;
        end

        // A rejected push in the same cycle as a STATUS store must win.
        if (status_wr) begin
            overflow_d = 1'b0;
        end
        if (push_try && !push_ok) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage has no reset. A push in a reset cycle may land here, but
    // the pointers are cleared, so that word is never visible.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= WriteDataM;
        end
    end

    // RAM writes happen even during reset; the core's stores are not
    // suppressed by the responder.
    always_ff @(posedge clk) begin
        if (MemWriteM && !is_mmio) begin
            ram_mem[ram_idx] <= WriteDataM;
        end
    end

    always_comb begin
        ReadDataM = 32'h0;
        if (is_mmio) begin
            case (mmio_off)
                OFF_CYCLES: ReadDataM = cycles_val;
                OFF_STATUS: ReadDataM = {16'b0, count_byte, 5'b0,
                                         overflow_q, fifo_full, fifo_empty};
                default:    ReadDataM = 32'h0;
            endcase
        end else begin
            ReadDataM = ram_mem[ram_idx];
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder. A small FIFO/status model runs
// beside the DUT, and every accepted push is queued in a scoreboard that
// is compared against the DUT head whenever the model predicts a pop.

module tb_dmem_responder;

    localparam int DEPTH = 8;

    logic        clk;
    logic        reset;
    logic        MemWriteM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        dbg_valid;
    logic [31:0] dbg_data;
    logic        dbg_ready;

    int checkCount;
    int errorCount;

    logic [31:0] scoreboard [$];
    int          modelCount;
    logic        modelOverflow;
    logic [31:0] modelCycles;

    dmem_responder #(.ADDR_W(6), .FIFO_AW(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWriteM  (MemWriteM),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .dbg_valid  (dbg_valid),
        .dbg_data   (dbg_data),
        .dbg_ready  (dbg_ready)
    );

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drives the memory-stage inputs for the coming cycle
    task automatic applyStimulus(input logic we, input logic [31:0] addr,
                                 input logic [31:0] data);
        MemWriteM  = we;
        ALUOutM    = addr;
        WriteDataM = data;
    endtask

    function automatic logic [31:0] statusWord();
        logic [31:0] s;
        s = 32'h0;
        s[15:8] = 8'(modelCount);
        s[2]    = modelOverflow;
        s[1]    = (modelCount == DEPTH);
        s[0]    = (modelCount == 0);
        return s;
    endfunction

    function automatic logic [31:0] cyclesWord();
`ifdef DMEM_CYCLE_COUNTER_EN
        return modelCycles;
`else
        return 32'h0;
`endif
    endfunction

    // Advances one clock edge, updating the model and checking any pop
    task automatic tick();
        logic        popM;
        logic        pushTry;
        logic        pushOk;
        logic        statusWr;
        logic [31:0] expHead;
        popM     = !reset && (modelCount != 0) && dbg_ready;
        pushTry  = !reset && MemWriteM && (ALUOutM[31:2] == 30'h3FFFFFFC);
        statusWr = !reset && MemWriteM && (ALUOutM[31:2] == 30'h3FFFFFFE);
        pushOk   = pushTry && ((modelCount < DEPTH) || popM);
        if (popM) begin
            checkOutput("pop_valid", {31'b0, dbg_valid}, 32'h1);
            expHead = scoreboard.pop_front();
            checkOutput("pop_data", dbg_data, expHead);
        end
        if (pushOk) scoreboard.push_back(WriteDataM);
        if (reset) begin
            scoreboard.delete();
            modelCount    = 0;
            modelOverflow = 1'b0;
            modelCycles   = 32'h0;
        end else begin
            modelCount  = modelCount + (pushOk ? 1 : 0) - (popM ? 1 : 0);
            if (statusWr) modelOverflow = 1'b0;
            if (pushTry && !pushOk) modelOverflow = 1'b1;
            modelCycles = modelCycles + 32'd1;
        end
        @(posedge clk);
        #1;
        checkOutput("valid", {31'b0, dbg_valid}, {31'b0, modelCount != 0});
    endtask

    task automatic storeWord(input logic [31:0] addr, input logic [31:0] data);
        applyStimulus(1'b1, addr, data);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0);
    endtask

    task automatic loadCheck(input string tag, input logic [31:0] addr,
                             input logic [31:0] exp);
        applyStimulus(1'b0, addr, 32'h0);
        #1;
        checkOutput(tag, ReadDataM, exp);
    endtask

    initial begin
        checkCount    = 0;
        errorCount    = 0;
        modelCount    = 0;
        modelOverflow = 1'b0;
        modelCycles   = 32'h0;
        reset         = 1'b1;
        dbg_ready     = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0);

        // Reset state
        tick();
        tick();
        reset = 1'b0;
        checkOutput("rst_valid", {31'b0, dbg_valid}, 32'h0);
        loadCheck("rst_status", 32'hFFFFFFF8, 32'h00000001);
        loadCheck("rst_cycles", 32'hFFFFFFF4, cyclesWord());

        // RAM write/read, aliasing, same-cycle read-before-write
        storeWord(32'h00000000, 32'hA5A5A5A5);
        storeWord(32'h00000010, 32'hDEADBEEF);
        loadCheck("ram_rd", 32'h00000010, 32'hDEADBEEF);
        loadCheck("ram_alias", 32'h00000110, 32'hDEADBEEF);
        loadCheck("ram_lsb_ign", 32'h00000013, 32'hDEADBEEF);
        applyStimulus(1'b1, 32'h00000010, 32'h12345678);
        #1;
        checkOutput("ram_same_cycle", ReadDataM, 32'hDEADBEEF);
        tick();
        loadCheck("ram_new", 32'h00000010, 32'h12345678);

        // FIFO stream with the consumer stalled, then drained
        for (int i = 1; i <= 3; i++) storeWord(32'hFFFFFFF0, 32'(i));
        loadCheck("fifo_status3", 32'hFFFFFFF8, 32'h00000300);
        loadCheck("txdata_rd", 32'hFFFFFFF0, 32'h0);
        checkOutput("head_hold0", dbg_data, 32'h1);
        tick();
        checkOutput("head_hold1", dbg_data, 32'h1);
        loadCheck("no_pop_on_rd", 32'hFFFFFFF8, 32'h00000300);
        dbg_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        dbg_ready = 1'b0;
        checkOutput("drain_valid", {31'b0, dbg_valid}, 32'h0);
        loadCheck("drain_status", 32'hFFFFFFF8, 32'h00000001);

        // Full and overflow, STATUS clear, push-while-full with a pop
        for (int i = 0; i < 9; i++) storeWord(32'hFFFFFFF0, 32'h100 + 32'(i));
        loadCheck("ovf_status", 32'hFFFFFFF8, 32'h00000806);
        storeWord(32'hFFFFFFF8, 32'hFFFFFFFF);
        loadCheck("ovf_clear", 32'hFFFFFFF8, 32'h00000802);
        dbg_ready = 1'b1;
        storeWord(32'hFFFFFFF0, 32'h00000099);
        dbg_ready = 1'b0;
        loadCheck("full_push_pop", 32'hFFFFFFF8, statusWord());
        loadCheck("full_push_pop_c", 32'hFFFFFFF8, 32'h00000802);
        dbg_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) tick();
        dbg_ready = 1'b0;
        loadCheck("full_drained", 32'hFFFFFFF8, 32'h00000001);

        // Cycle counter
        loadCheck("cycles_a", 32'hFFFFFFF4, cyclesWord());
        for (int i = 0; i < 5; i++) tick();
        loadCheck("cycles_b", 32'hFFFFFFF4, cyclesWord());
        storeWord(32'hFFFFFFF4, 32'h0);
        loadCheck("cycles_st_ign", 32'hFFFFFFF4, cyclesWord());

        // Reset mid-stream: RAM store still lands, MMIO store is dropped
        for (int i = 0; i < 5; i++) storeWord(32'hFFFFFFF0, 32'h200 + 32'(i));
        loadCheck("pre_rst_status", 32'hFFFFFFF8, 32'h00000500);
        reset = 1'b1;
        storeWord(32'h00000020, 32'h00000055);
        reset = 1'b0;
        checkOutput("midrst_valid", {31'b0, dbg_valid}, 32'h0);
        loadCheck("midrst_status", 32'hFFFFFFF8, 32'h00000001);
        loadCheck("midrst_ram", 32'h00000010, 32'h12345678);
        loadCheck("rst_ram_wr", 32'h00000020, 32'h00000055);
        reset = 1'b1;
        storeWord(32'hFFFFFFF0, 32'h00000077);
        reset = 1'b0;
        loadCheck("rst_push_drop", 32'hFFFFFFF8, 32'h00000001);
        loadCheck("rst_cycles0", 32'hFFFFFFF4, cyclesWord());

        // Unmapped MMIO
        loadCheck("unmapped_rd", 32'hFFFFFF00, 32'h0);
        storeWord(32'hFFFFFF00, 32'h0000FFFF);
        loadCheck("unmapped_ram0", 32'h00000000, 32'hA5A5A5A5);
        loadCheck("unmapped_status", 32'hFFFFFF00 | 32'hF8, 32'h00000001);
        loadCheck("unmapped_fc", 32'hFFFFFFFC, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
